// File: rtl/core_pkg.sv
// Shared micro-op field positions and bundle-count encoding for decode, queue and execute.
package core_pkg;

    localparam int unsigned UOP_W_DEF       = 20;
    localparam int unsigned FLAG_WR_BIT_DEF = 12;
    localparam int unsigned FLAG_RD_BIT_DEF = 15;
    localparam int unsigned CNT_W           = 2;

    // in_count carries "number of uops minus one"
    typedef logic [CNT_W-1:0] ucnt_t;

    function automatic int unsigned uop_num(ucnt_t cnt);
        return 32'(cnt) + 32'd1;
    endfunction

endpackage

// File: rtl/uop_queue_if.sv
// Decoder-to-queue bundle handshake and queue-to-execute issue handshake.
interface uop_queue_if
    import core_pkg::*;
#(
    parameter int unsigned UOP_W    = UOP_W_DEF,
    parameter int unsigned MAX_UOPS = 3
);

    logic                      in_valid;
    logic                      in_ready;
    logic [MAX_UOPS*UOP_W-1:0] in_uops;
    ucnt_t                     in_count;
    logic                      out_valid;
    logic                      out_ready;
    logic [UOP_W-1:0]          out_uop;
    logic                      out_last;

    modport master (
        output in_valid, in_uops, in_count, out_ready,
        input  in_ready, out_valid, out_uop, out_last
    );

    modport slave (
        input  in_valid, in_uops, in_count, out_ready,
        output in_ready, out_valid, out_uop, out_last
    );

endinterface

// File: rtl/uop_ring.sv
// Queue storage: several same-cycle writes to distinct entries, one asynchronous read port.
module uop_ring #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 21,
    parameter int unsigned LANES = 3
) (
    input  logic                                  clk,
    input  logic [LANES-1:0]                      wr_en,
    input  logic [LANES-1:0][$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [LANES-1:0][WIDTH-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0]              rd_addr,
    output logic [WIDTH-1:0]                      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately unreset; pointers alone define validity
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(LANES); k++) begin
            if (wr_en[k]) begin
                mem[wr_addr[k]] <= wr_data[k];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uop_queue.sv
// Micro-op queue between decode and execute with a status-flag scoreboard.
module uop_queue
    import core_pkg::*;
#(
    parameter int unsigned UOP_W       = UOP_W_DEF,
    parameter int unsigned MAX_UOPS    = 3,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FLAG_WR_BIT = FLAG_WR_BIT_DEF,
    parameter int unsigned FLAG_RD_BIT = FLAG_RD_BIT_DEF
) (
    input  logic                     clk,
    input  logic                     a_rst,
    input  logic                     hold,
    input  logic                     flush,
    input  logic                     sf_written,
    output logic                     sf_busy,
    output logic [$clog2(DEPTH):0]   occupancy,
    uop_queue_if.slave               bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;
    localparam int unsigned RW = UOP_W + 1;

    logic [PW-1:0]                  rd_ptr;
    logic [PW-1:0]                  wr_ptr;
    logic [RW-1:0]                  head;
    logic [MAX_UOPS-1:0]            wen;
    logic [MAX_UOPS-1:0][PW-1:0]    waddr;
    logic [MAX_UOPS-1:0][RW-1:0]    wdata;
    logic                           empty_c;
    logic                           accept_c;
    logic                           issue_c;

    assign empty_c       = (occupancy == '0);
    assign bus.out_uop   = head[UOP_W-1:0];
    assign bus.out_last  = head[UOP_W] & ~empty_c;
    assign bus.out_valid = ~empty_c & ~hold & ~(sf_busy & head[FLAG_RD_BIT]);
    // Free space is judged before any same-cycle issue
    assign bus.in_ready  = (DEPTH - 32'(occupancy)) >= uop_num(bus.in_count);
    assign accept_c      = bus.in_valid & bus.in_ready & ~hold & ~flush;
    assign issue_c       = bus.out_valid & bus.out_ready & ~flush;

    // Slot k lands at wr_ptr + (in_count - k): the highest slot issues first, slot 0 last
    always_comb begin
        wen   = '0;
        waddr = '0;
        wdata = '0;
        for (int k = 0; k < int'(MAX_UOPS); k++) begin
            wen[k]   = accept_c && (32'(k) <= 32'(bus.in_count));
            waddr[k] = wr_ptr + PW'(bus.in_count) - PW'(k);
            wdata[k] = {(k == 0), bus.in_uops[k*UOP_W +: UOP_W]};
        end
    end

    uop_ring #(
        .DEPTH (DEPTH),
        .WIDTH (RW),
        .LANES (MAX_UOPS)
    ) u_ring (
        .clk     (clk),
        .wr_en   (wen),
        .wr_addr (waddr),
        .wr_data (wdata),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            sf_busy   <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            sf_busy   <= 1'b0;
        end else if (!hold) begin
            if (accept_c) begin
                wr_ptr <= wr_ptr + PW'(uop_num(bus.in_count));
            end
            if (issue_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occupancy <= occupancy + (accept_c ? OW'(uop_num(bus.in_count)) : OW'(0))
                         - OW'(issue_c);
            // A new flag writer wins over a same-cycle commit of the older one
            if (issue_c && head[FLAG_WR_BIT]) begin
                sf_busy <= 1'b1;
            end else if (sf_written) begin
                sf_busy <= 1'b0;
            end
        end
    end

endmodule
